// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared types and constants for the branch resolve unit
// Purpose: prediction queue entry type and the sequential PC step.
// Contents: BRU_ADDR_W (entry field width), BRU_PC_STEP, BranchPredEntry.
package branch_resolve_unit_pkg;

  localparam int unsigned BRU_ADDR_W  = 32;
  localparam int unsigned BRU_PC_STEP = 4;

  // Fields are sized for the widest supported PC; narrower builds zero-extend.
  typedef struct packed {
    logic [BRU_ADDR_W-1:0] pc;
    logic                  predTaken;
    logic [BRU_ADDR_W-1:0] predTarget;
  } BranchPredEntry;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/execute/training bus of the branch resolve unit
// Purpose: bundles fetch push, execute resolve and the registered training/flush outputs.
// Modports: master = fetch/execute side (drives pushes and resolves),
//           slave  = branch_resolve_unit (drives queue_full, training, flush, redirect).
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_pred_taken;
  logic [ADDR_W-1:0] fetch_pred_target;
  logic              queue_full;
  logic              exe_valid;
  logic              exe_taken;
  logic [ADDR_W-1:0] exe_target;
  logic              isBranch;
  logic              isBranchTaken;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              protocol_err;

  modport master (
    output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    output exe_valid, exe_taken, exe_target,
    input  queue_full, isBranch, isBranchTaken, flush, redirect_pc, protocol_err
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    input  exe_valid, exe_taken, exe_target,
    output queue_full, isBranch, isBranchTaken, flush, redirect_pc, protocol_err
  );
endinterface

// File: rtl/branch_resolve_unit_branch_pred_queue.sv
// rtl/branch_resolve_unit_branch_pred_queue.sv - in-order queue of in-flight branch predictions
// Purpose: circular buffer with wrap-bit pointers; clear collapses the queue onto the popped pointer.
// Ports: clk, rst (async active-low), push/push_entry, pop, clear, head, full, empty.
module branch_pred_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  BranchPredEntry push_entry,
  input  logic           pop,
  input  logic           clear,
  output BranchPredEntry head,
  output logic           full,
  output logic           empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  rd_next;
  logic [PW-1:0]  count;
  logic           do_push;
  logic           do_pop;
  BranchPredEntry mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr[IW-1:0]];
  assign rd_next = rd_ptr + PW'(1);
  // A clear always accompanies a mispredicting pop, so any same-cycle push is wrong-path.
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= rd_next;
      rd_ptr <= rd_next;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution, predictor training and redirect
// Purpose: compares the oldest queued prediction against the execute outcome; emits registered
//          training pulse, one-cycle flush and redirect PC; flags resolves with an empty queue.
// Ports: clk, rst (async active-low), bus (slave modport), branch_count, mispredict_count.
// Optional: BRU_PERF_COUNTER_EN builds saturating branch/mispredict counters; otherwise both read 0.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  BranchPredEntry    push_entry;
  BranchPredEntry    head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              mispredict;
  logic [ADDR_W-1:0] seq_pc;

  // Wrong-path fetches arriving while flush is high are ignored.
  assign push = bus.fetch_valid && !full && !bus.flush;
  assign pop  = bus.exe_valid && !empty;

  assign push_entry.pc         = BRU_ADDR_W'(bus.fetch_pc);
  assign push_entry.predTaken  = bus.fetch_pred_taken;
  assign push_entry.predTarget = BRU_ADDR_W'(bus.fetch_pred_target);

  assign mispredict = pop && ((head.predTaken != bus.exe_taken) ||
                              (bus.exe_taken && head.predTaken &&
                               (head.predTarget[ADDR_W-1:0] != bus.exe_target)));

  // Fall-through PC wraps naturally at 2^ADDR_W.
  assign seq_pc = head.pc[ADDR_W-1:0] + ADDR_W'(BRU_PC_STEP);

  branch_pred_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (mispredict),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  assign bus.queue_full = full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.isBranch      <= 1'b0;
      bus.isBranchTaken <= 1'b0;
      bus.flush         <= 1'b0;
      bus.redirect_pc   <= '0;
      bus.protocol_err  <= 1'b0;
    end else begin
      bus.isBranch      <= pop;
      bus.isBranchTaken <= pop && bus.exe_taken;
      bus.flush         <= mispredict;
      if (mispredict) begin
        bus.redirect_pc <= bus.exe_taken ? bus.exe_target : seq_pc;
      end
      if (bus.exe_valid && empty) begin
        bus.protocol_err <= 1'b1;
      end
    end
  end

`ifdef BRU_PERF_COUNTER_EN
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (pop && (br_cnt != '1))        br_cnt <= br_cnt + 32'd1;
      if (mispredict && (mp_cnt != '1)) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign branch_count     = br_cnt;
  assign mispredict_count = mp_cnt;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  int          total;
  int          bad;

  branch_resolve_unit_if #(.ADDR_W(32)) bus ();

  branch_resolve_unit #(
    .DEPTH  (4),
    .ADDR_W (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    bus.fetch_valid       = 1'b1;
    bus.fetch_pc          = pc;
    bus.fetch_pred_taken  = t;
    bus.fetch_pred_target = tgt;
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic resolve(input logic t, input logic [31:0] tgt);
    bus.exe_valid  = 1'b1;
    bus.exe_taken  = t;
    bus.exe_target = tgt;
    tick();
    bus.exe_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_isBranch"}, 64'(bus.isBranch), 64'd0);
    chk({tag, "_isBranchTaken"}, 64'(bus.isBranchTaken), 64'd0);
    chk({tag, "_flush"}, 64'(bus.flush), 64'd0);
    chk({tag, "_redirect"}, 64'(bus.redirect_pc), 64'd0);
    chk({tag, "_perr"}, 64'(bus.protocol_err), 64'd0);
    chk({tag, "_full"}, 64'(bus.queue_full), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.fetch_valid       = 1'b0;
    bus.fetch_pc          = '0;
    bus.fetch_pred_taken  = 1'b0;
    bus.fetch_pred_target = '0;
    bus.exe_valid         = 1'b0;
    bus.exe_taken         = 1'b0;
    bus.exe_target        = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Correctly predicted not-taken branch
    push(32'h100, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    chk("t1_isBranch", 64'(bus.isBranch), 64'd1);
    chk("t1_taken", 64'(bus.isBranchTaken), 64'd0);
    chk("t1_flush", 64'(bus.flush), 64'd0);
    tick();
    chk("t1_pulse_one_cycle", 64'(bus.isBranch), 64'd0);

    // Direction mispredict: predicted NT, actually taken
    push(32'h200, 1'b0, 32'h0);
    resolve(1'b1, 32'h400);
    chk("t2_isBranch", 64'(bus.isBranch), 64'd1);
    chk("t2_taken", 64'(bus.isBranchTaken), 64'd1);
    chk("t2_flush", 64'(bus.flush), 64'd1);
    chk("t2_redirect", 64'(bus.redirect_pc), 64'h400);
    chk("t2_full", 64'(bus.queue_full), 64'd0);
    tick();
    chk("t2_flush_one_cycle", 64'(bus.flush), 64'd0);
    chk("t2_redirect_hold", 64'(bus.redirect_pc), 64'h400);

    // Target mispredict
    push(32'h300, 1'b1, 32'h500);
    resolve(1'b1, 32'h600);
    chk("t3_flush", 64'(bus.flush), 64'd1);
    chk("t3_redirect", 64'(bus.redirect_pc), 64'h600);
    tick();

    // Predicted taken, actually not taken at top of address space: pc+4 wraps
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    resolve(1'b0, 32'h0);
    chk("t3_wrap_flush", 64'(bus.flush), 64'd1);
    chk("t3_wrap_taken", 64'(bus.isBranchTaken), 64'd0);
    chk("t3_wrap_redirect", 64'(bus.redirect_pc), 64'h0);
    tick();

    // Fill the queue across the pointer wrap, drop a 5th push, drain back-to-back
    push(32'h1000, 1'b0, 32'h0);
    push(32'h1010, 1'b1, 32'h2000);
    push(32'h1020, 1'b0, 32'h0);
    chk("t4_not_full_3", 64'(bus.queue_full), 64'd0);
    push(32'h1030, 1'b1, 32'h3000);
    chk("t4_full", 64'(bus.queue_full), 64'd1);
    push(32'h1040, 1'b0, 32'h0);
    chk("t4_full_after_drop", 64'(bus.queue_full), 64'd1);
    bus.exe_valid  = 1'b1;
    bus.exe_taken  = 1'b0;
    bus.exe_target = 32'h0;
    #1;
    chk("t4_full_same_cycle_pop", 64'(bus.queue_full), 64'd1);
    tick();
    chk("t4_p0_isBranch", 64'(bus.isBranch), 64'd1);
    chk("t4_p0_taken", 64'(bus.isBranchTaken), 64'd0);
    chk("t4_p0_flush", 64'(bus.flush), 64'd0);
    bus.exe_taken  = 1'b1;
    bus.exe_target = 32'h2000;
    tick();
    chk("t4_p1_isBranch", 64'(bus.isBranch), 64'd1);
    chk("t4_p1_taken", 64'(bus.isBranchTaken), 64'd1);
    chk("t4_p1_flush", 64'(bus.flush), 64'd0);
    bus.exe_taken  = 1'b0;
    bus.exe_target = 32'h0;
    tick();
    chk("t4_p2_isBranch", 64'(bus.isBranch), 64'd1);
    chk("t4_p2_flush", 64'(bus.flush), 64'd0);
    bus.exe_taken  = 1'b1;
    bus.exe_target = 32'h3000;
    tick();
    bus.exe_valid = 1'b0;
    chk("t4_p3_isBranch", 64'(bus.isBranch), 64'd1);
    chk("t4_p3_taken", 64'(bus.isBranchTaken), 64'd1);
    chk("t4_p3_flush", 64'(bus.flush), 64'd0);
    chk("t4_empty_not_full", 64'(bus.queue_full), 64'd0);
    chk("t4_perr_clear", 64'(bus.protocol_err), 64'd0);
    resolve(1'b0, 32'h0);
    chk("t4_dropped_no_pop", 64'(bus.isBranch), 64'd0);
    chk("t4_perr_set", 64'(bus.protocol_err), 64'd1);

    // Async reset between edges clears sticky state immediately
    #3;
    rst = 1'b0;
    #1;
    chk_idle_outputs("async1");
    tick();
    rst = 1'b1;
    tick();

    // Mispredict with younger entries and a concurrent push: all discarded
    push(32'h9000, 1'b0, 32'h0);
    push(32'h9010, 1'b0, 32'h0);
    push(32'h9020, 1'b0, 32'h0);
    bus.fetch_valid       = 1'b1;
    bus.fetch_pc          = 32'h9030;
    bus.fetch_pred_taken  = 1'b0;
    bus.fetch_pred_target = 32'h0;
    resolve(1'b1, 32'h7000);
    chk("t5_flush", 64'(bus.flush), 64'd1);
    chk("t5_redirect", 64'(bus.redirect_pc), 64'h7000);
    // fetch_valid still high during flush: ignored as wrong-path
    tick();
    bus.fetch_valid = 1'b0;
    chk("t5_perr_before", 64'(bus.protocol_err), 64'd0);
    resolve(1'b0, 32'h0);
    chk("t5_no_pop", 64'(bus.isBranch), 64'd0);
    chk("t5_no_flush", 64'(bus.flush), 64'd0);
    chk("t5_perr_set", 64'(bus.protocol_err), 64'd1);
    tick();
    tick();
    chk("t5_perr_sticky", 64'(bus.protocol_err), 64'd1);
    chk("t5_redirect_hold", 64'(bus.redirect_pc), 64'h7000);

    // Async reset with entries queued drops them
    push(32'hA000, 1'b0, 32'h0);
    push(32'hA010, 1'b0, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk_idle_outputs("async2");
    tick();
    rst = 1'b1;
    tick();
    resolve(1'b0, 32'h0);
    chk("async2_queue_empty", 64'(bus.isBranch), 64'd0);
    chk("async2_perr", 64'(bus.protocol_err), 64'd1);

    // Performance counters: 10 resolves, 3 mispredicts (i = 0, 3, 6)
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      push(32'h4000 + 32'(i) * 32'h10, 1'b0, 32'h0);
      resolve((i % 3 == 0) && (i < 9), 32'h8000);
      tick();
    end
`ifdef BRU_PERF_COUNTER_EN
    chk("perf_branch_count", 64'(branch_count), 64'd10);
    chk("perf_mispredict_count", 64'(mispredict_count), 64'd3);
`else
    chk("perf_branch_count_tied", 64'(branch_count), 64'd0);
    chk("perf_mispredict_count_tied", 64'(mispredict_count), 64'd0);
`endif
    chk("perf_redirect_last", 64'(bus.redirect_pc), 64'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage counterpart of the fetch-side 2-bit branch predictor. Tracks in-flight predictions from fetch in order and compares each against the real outcome at execute.
- Produces the registered isBranch/isBranchTaken training pulse that the predictor consumes.
- On a mispredict, produces a one-cycle flush plus a redirect PC for the fetch unit.

Parameters:
- DEPTH, 4, prediction queue entries (power of 2, ≥2).
- ADDR_W, 32, PC/target width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- fetch_valid  in  1  a fetched branch is entering the pipe; push its prediction
- fetch_pc  in  ADDR_W  PC of that branch
- fetch_pred_taken  in  1  predictor's taken/not-taken
- fetch_pred_target  in  ADDR_W  predicted target (meaningful only if taken)
- queue_full  out  1  queue holds DEPTH entries; fetch must stall branches
- exe_valid  in  1  oldest in-flight branch resolved this cycle
- exe_taken  in  1  actual direction
- exe_target  in  ADDR_W  actual target
- isBranch  out  1  predictor training strobe
- isBranchTaken  out  1  actual direction for training
- flush  out  1  squash younger instructions
- redirect_pc  out  ADDR_W  fetch restart PC, valid when flush=1
- protocol_err  out  1  sticky; resolve seen with empty queue

Behaviour:
- Reset (rst=0, async): queue empty, read/write pointers 0. Outputs: isBranch=0, isBranchTaken=0, flush=0, redirect_pc=0, protocol_err=0, queue_full=0.
- Queue: circular buffer, pointers of log2(DEPTH)+1 bits. Wrap bit distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- queue_full: combinational from current count. Fullness does not depend on a same-cycle pop.
- Push condition: fetch_valid && !queue_full && !flush. A push attempted while full is dropped (fetch protocol violation; not flagged).
- Pop condition: exe_valid && !empty. Pop uses the head entry.
- exe_valid with an empty queue: no pop, no training, no flush; protocol_err set at the next edge. It stays set until reset.
- Mispredict when either holds:
  - head.pred_taken != exe_taken
  - exe_taken && head.pred_taken && head.pred_target != exe_target
- Outputs are registered with a latency of 1 cycle after the resolving exe_valid edge:
  - isBranch=1 and isBranchTaken=exe_taken for exactly one cycle per valid pop; otherwise 0.
  - On mispredict: flush=1 for one cycle. redirect_pc = exe_taken ? exe_target : fetch PC stored in head + 4, modulo 2^ADDR_W. The pc+4 wraps at 2^ADDR_W.
  - redirect_pc holds its last value when flush=0.
- Mispredict clears the queue at the same edge that registers flush: both pointers are set to the popped pointer. All younger entries are wrong-path.
- During the cycle flush=1, fetch_valid is ignored (wrong-path fetch).
- Simultaneous push and pop with no mispredict: both occur and the count is unchanged.
- Simultaneous push and pop with a mispredict: the push is discarded.
- Back-to-back exe_valid: one training pulse per cycle, no bubbles.
- A mispredict on consecutive resolves is impossible after a clear: the queue is empty, so the second resolve becomes a protocol_err case.

Optional Feature:
- Macro: BRU_PERF_COUNTER_EN.
- When defined, adds outputs branch_count[31:0] and mispredict_count[31:0].
  - Both are 0 at reset.
  - branch_count increments on every valid pop; mispredict_count increments on every flush-causing pop.
  - Both saturate at 0xFFFFFFFF.
- When undefined, both ports exist but are tied to 0, and no counter flops are built.

Decomposition:
- Shared package (alongside BasicTypes/PipelineTypes):
  - typedef BranchPredEntry {pc, predTaken, predTarget}
  - constant BRU_PC_STEP=4
- Natural sub-module: branch_pred_queue. It owns storage, pointers, full/empty and the clear input.
- branch_resolve_unit keeps the compare logic, output registers and counters.

Test Plan:
- Reset → all outputs 0. Push 0x100 not-taken, resolve exe_taken=0 → next cycle isBranch=1, isBranchTaken=0, flush=0.
- Push pc=0x200 predicted not-taken, resolve exe_taken=1, exe_target=0x400 → isBranch=1, isBranchTaken=1, flush=1, redirect_pc=0x400. Queue empty afterwards.
- Push 0x300 predicted taken to 0x500, resolve taken to 0x600 → flush=1, redirect_pc=0x600. Push 0xFFFFFFFC predicted taken, resolve not-taken → redirect_pc=0x0.
- Push 4 entries → queue_full=1. A 5th push is dropped. Resolve all 4 correctly across a pointer wrap → 4 consecutive isBranch pulses; queue empties with queue_full=0.
- Three entries queued, first mispredicts while fetch_valid=1 → queue cleared, concurrent push discarded. A subsequent exe_valid sets protocol_err=1, which persists. Async rst mid-stream clears all state immediately.
- With BRU_PERF_COUNTER_EN: 10 resolves, 3 mispredicts → branch_count=10, mispredict_count=3.
